// File: rtl/seq_borrow_chain_subtractor.sv
`default_nettype none
// ============================================================================
// seq_borrow_chain_subtractor: multi-cycle a - b - Bin, DIGIT bits per clock,
// behind valid/ready. Optional SUB_ADD_MODE_EN adds an 'add' port (a + b + Bin).
// Revision: 1.0
// ============================================================================
module seq_borrow_chain_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bin,
`ifdef SUB_ADD_MODE_EN
    input  logic             add,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             V
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             add_reg;
    logic             accept;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_res;
    logic             v_calc;
    int               lsb;

    assign accept = in_valid && in_ready;

`ifdef SUB_ADD_MODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_reg <= 1'b0;
        end else if (accept) begin
            add_reg <= add;
        end
    end
`else
    assign add_reg = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // brw holds the borrow in subtract mode and the carry in add mode.
    always_comb begin
        lsb   = int'(cnt) * DIGIT;
        a_dig = a_reg[lsb +: DIGIT];
        b_dig = b_reg[lsb +: DIGIT];
        if (add_reg) begin
            dig_res = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, brw};
            v_calc  = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (dig_res[DIGIT-1] != a_reg[WIDTH-1]);
        end else begin
            dig_res = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw};
            v_calc  = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                      (dig_res[DIGIT-1] != a_reg[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            Diff  <= '0;
            Bout  <= 1'b0;
            V     <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            brw   <= Bin;
            cnt   <= '0;
        end else if (state == RUN) begin
            Diff[lsb +: DIGIT] <= dig_res[DIGIT-1:0];
            brw                <= dig_res[DIGIT];
            cnt                <= cnt + CW'(1);
            // The last digit carries the result MSB, so flags resolve here.
            if (cnt == LAST) begin
                Bout <= dig_res[DIGIT];
                V    <= v_calc;
            end
        end
    end

endmodule
`default_nettype wire
